peltier_regulator: RTL and testbench

Closed-loop temperature regulator for one Peltier cooler. It periodically requests a conversion from the MCP3008 interface, consumes the returned sample over the avail/accept handshake, and runs a shift-scaled PI law. The resulting 8-bit duty cycle replaces the host-written register that feeds the Peltier PWM comparator. It sits directly downstream of the MCP3008 interface, in parallel with the TX multiplexer's MCP input.

---
 rtl/peltier_regulator.sv | 149 ++++++++++++++
 tb/tb_peltier_regulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/peltier_regulator.sv
// Closed-loop Peltier temperature regulator: polls the MCP3008 interface once per
// PERIOD, runs a shift-scaled PI law on the returned code and drives an 8-bit duty.
`timescale 1ns/1ps
module peltier_regulator #(
    parameter logic [2:0]  CHANNEL  = 3'd0,
    parameter int unsigned PERIOD   = 1_000_000,
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned KP_SHIFT = 2,
    parameter int unsigned KI_SHIFT = 6,
    parameter logic [9:0]  LIMIT    = 10'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  setpoint,
    output logic        sample_req,
    input  logic [15:0] sample_in,
    input  logic        sample_avail,
    output logic        sample_accept,
    output logic [7:0]  duty_out,
    output logic        over_temp,
    output logic        no_response
);

    localparam int unsigned TW = $clog2(PERIOD);
    localparam int unsigned OW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TICK_LOAD = TW'(PERIOD - 1);
    localparam logic [OW-1:0] TMO_LAST  = OW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_TICK, REQ, WAIT_DATA, CALC1, CALC2, DRAIN
    } state_t;

    state_t state, next_state;

    logic [TW-1:0]       tick_cnt;
    logic [OW-1:0]       tmo_cnt;
    logic                tick, tmo_last, req_second, chan_match;
    logic [9:0]          code_r;
    logic signed [10:0]  err_now, err_r;
    logic signed [15:0]  integ, integ_next;
    logic signed [16:0]  integ_sum;
    logic signed [19:0]  err_ext, integ_ext, pi_sum;
    logic [7:0]          duty_clamped;
    logic                unused_bits;

    assign unused_bits = ^sample_in[15:13];
    assign tick        = (tick_cnt == '0);
    assign tmo_last    = (tmo_cnt == TMO_LAST);
    assign chan_match  = (sample_in[12:10] == CHANNEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        sample_req    = 1'b0;
        sample_accept = 1'b0;
        case (state)
            IDLE:      if (enable) next_state = WAIT_TICK;
            WAIT_TICK: begin
                if (!enable)   next_state = IDLE;
                else if (tick) next_state = REQ;
            end
            REQ: begin
                sample_req = 1'b1;
                if (!enable)         next_state = IDLE;
                else if (req_second) next_state = WAIT_DATA;
            end
            WAIT_DATA: begin
                // An in-flight conversion must be drained so it cannot be used after re-enable
                if (!enable) next_state = DRAIN;
                else if (sample_avail) begin
                    sample_accept = 1'b1;
                    next_state    = chan_match ? CALC1 : WAIT_TICK;
                end else if (tmo_last) next_state = WAIT_TICK;
            end
            CALC1: next_state = enable ? CALC2 : IDLE;
            CALC2: next_state = enable ? WAIT_TICK : IDLE;
            DRAIN: begin
                if (sample_avail) begin
                    sample_accept = 1'b1;
                    next_state    = IDLE;
                end else if (tmo_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        err_now    = {1'b0, code_r} - {1'b0, setpoint};
        integ_sum  = {integ[15], integ} + {{6{err_now[10]}}, err_now};
        // Saturate instead of wrapping when the 17-bit sum leaves the 16-bit range
        if (integ_sum[16] != integ_sum[15])
            integ_next = integ_sum[16] ? 16'sh8000 : 16'sh7FFF;
        else
            integ_next = integ_sum[15:0];
        err_ext    = {{9{err_r[10]}}, err_r};
        integ_ext  = {{4{integ[15]}}, integ};
        pi_sum     = (err_ext <<< KP_SHIFT) + (integ_ext >>> KI_SHIFT);
        if (pi_sum[19])               duty_clamped = '0;
        else if (pi_sum > 20'sd255)   duty_clamped = '1;
        else                          duty_clamped = pi_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt    <= '0;
            tmo_cnt     <= '0;
            req_second  <= 1'b0;
            code_r      <= '0;
            err_r       <= '0;
            integ       <= '0;
            duty_out    <= '0;
            over_temp   <= 1'b0;
            no_response <= 1'b0;
        end else begin
            tick_cnt   <= (state == IDLE || tick) ? TICK_LOAD : tick_cnt - 1'b1;
            req_second <= (state == REQ) && !req_second;
            tmo_cnt    <= (state == next_state && (state == WAIT_DATA || state == DRAIN))
                          ? tmo_cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    integ       <= '0;
                    duty_out    <= '0;
                    over_temp   <= 1'b0;
                    no_response <= 1'b0;
                end
                WAIT_DATA: begin
                    if (enable && sample_avail) code_r <= sample_in[9:0];
                    if (enable && !sample_avail && tmo_last) begin
                        no_response <= 1'b1;
                        duty_out    <= '0;
                    end
                end
                CALC1: begin
                    err_r <= err_now;
                    integ <= integ_next;
                    if (code_r >= LIMIT) over_temp <= 1'b1;
                end
                CALC2: duty_out <= (over_temp || no_response) ? '0 : duty_clamped;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_peltier_regulator.sv
// Scoreboard bench for peltier_regulator: stimulus plays the MCP3008 interface and
// queues hand-computed duty/fault results; a monitor checks them 3 cycles after accept.
`timescale 1ns/1ps
module tb_peltier_regulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [9:0]  setpoint;
    logic        sample_req;
    logic [15:0] sample_in;
    logic        sample_avail;
    logic        sample_accept;
    logic [7:0]  duty_out;
    logic        over_temp;
    logic        no_response;

    int checks = 0;
    int failures = 0;
    int accept_count = 0;
    logic [9:0] exp_q[$];

    peltier_regulator #(
        .CHANNEL(3'd0), .PERIOD(64), .TIMEOUT(16),
        .KP_SHIFT(2), .KI_SHIFT(6), .LIMIT(10'd1000)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .setpoint(setpoint),
        .sample_req(sample_req), .sample_in(sample_in), .sample_avail(sample_avail),
        .sample_accept(sample_accept), .duty_out(duty_out),
        .over_temp(over_temp), .no_response(no_response)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic [9:0] ex(input logic [7:0] d, input logic ot, input logic nr);
        return {ot, nr, d};
    endfunction

    always @(negedge clk) if (!rst && sample_accept) accept_count++;

    // Monitor: each accept produces one result visible three cycles later
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst && sample_accept) begin
                repeat (3) @(negedge clk);
                if (exp_q.size() == 0) check("unexpected_accept", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("duty_out", duty_out, e[7:0]);
                    check("no_response", no_response, e[8]);
                    check("over_temp", over_temp, e[9]);
                end
            end
        end
    end

    task automatic wait_req(input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sample_req) break;
        end
        check(name, sample_req, 1);
    endtask

    // Called at the negedge where the first request cycle was seen
    task automatic serve(input logic [2:0] ch, input logic [9:0] code,
                         input logic [9:0] sp, input logic [9:0] expv);
        setpoint = sp;
        exp_q.push_back(expv);
        repeat (4) @(posedge clk);
        #1;
        sample_avail = 1'b1;
        sample_in    = {3'b000, ch, code};
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sample_accept) break;
        end
        check("accept_seen", sample_accept, 1);
        @(posedge clk); #1;
        sample_avail = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic toggle_enable();
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_duty", duty_out, 0);
        check("idle_over_temp", over_temp, 0);
        check("idle_no_response", no_response, 0);
        @(posedge clk); #1;
        enable = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int base;
        rst = 1'b1; enable = 1'b1; setpoint = 10'd500;
        sample_avail = 1'b0; sample_in = '0;

        // Reset held while a sample is offered
        repeat (3) @(posedge clk);
        #1;
        sample_avail = 1'b1;
        sample_in    = {6'd0, 10'd520};
        repeat (2) @(negedge clk);
        check("rst_duty", duty_out, 0);
        check("rst_sample_req", sample_req, 0);
        check("rst_sample_accept", sample_accept, 0);
        check("rst_over_temp", over_temp, 0);
        check("rst_no_response", no_response, 0);
        @(posedge clk); #1;
        sample_avail = 1'b0;

        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (sample_req) break;
        end
        check("first_req_seen", sample_req, 1);
        check("first_req_not_early", int'(cyc >= 65), 1);

        // Proportional, channel mismatch, saturation high
        serve(3'd0, 10'd520, 10'd500, ex(8'd80, 1'b0, 1'b0));
        wait_req("req_mismatch");
        serve(3'd3, 10'd100, 10'd500, ex(8'd80, 1'b0, 1'b0));
        wait_req("req_high");
        serve(3'd0, 10'd900, 10'd0, ex(8'd255, 1'b0, 1'b0));
        toggle_enable();

        // Negative clamp and integration
        for (int i = 0; i < 3; i++) begin
            wait_req("req_neg");
            serve(3'd0, 10'd400, 10'd500, ex(8'd0, 1'b0, 1'b0));
        end
        wait_req("req_236");
        serve(3'd0, 10'd560, 10'd500, ex(8'd236, 1'b0, 1'b0));

        // Timeout
        wait_req("req_timeout");
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (no_response) break;
        end
        check("timeout_flag", no_response, 1);
        check("timeout_duty", duty_out, 0);
        wait_req("req_after_timeout");
        serve(3'd0, 10'd520, 10'd500, ex(8'd0, 1'b0, 1'b1));

        // Over-temperature at exactly LIMIT, then sticky
        wait_req("req_ot");
        serve(3'd0, 10'd1000, 10'd500, ex(8'd0, 1'b1, 1'b1));
        wait_req("req_ot_sticky");
        serve(3'd0, 10'd500, 10'd500, ex(8'd0, 1'b1, 1'b1));
        toggle_enable();

        wait_req("req_clean");
        serve(3'd0, 10'd520, 10'd500, ex(8'd80, 1'b0, 1'b0));

        // Enable drop in WAIT_DATA: one pending word drained
        wait_req("req_drain");
        base = accept_count;
        exp_q.push_back(ex(8'd0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        sample_avail = 1'b1;
        sample_in    = {6'd0, 10'd520};
        repeat (3) @(posedge clk);
        #1;
        sample_avail = 1'b0;
        repeat (4) @(negedge clk);
        check("drain_accepts", accept_count - base, 1);
        check("drain_duty", duty_out, 0);
        @(posedge clk); #1;
        enable = 1'b1;

        // Integrator negative saturation, observed through a small positive error
        for (int i = 0; i < 33; i++) begin
            wait_req("req_sat");
            serve(3'd0, 10'd0, 10'd1023, ex(8'd0, 1'b0, 1'b0));
        end
        wait_req("req_sat_probe");
        serve(3'd0, 10'd130, 10'd0, ex(8'd10, 1'b0, 1'b0));

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
